// File: rtl/tanh_q_pkg.sv
// Shared 4-bit tanh input code definitions: code width, range limits and the code type.
package tanh_q_pkg;

  localparam int Q_W   = 4;
  localparam int Q_MIN = -8;
  localparam int Q_MAX = 7;

  typedef logic signed [Q_W-1:0] q4_t;

endpackage

// File: rtl/tanh_q_round_sat.sv
// Combinational requant datapath: round-half-up arithmetic right shift, and a separate
// clamp-to-q4 path so the caller can put a register between the two halves.
module tanh_q_round_sat
  import tanh_q_pkg::*;
#(
  parameter int ACC_W   = 16,
  parameter int SHIFT_W = 4
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic        [SHIFT_W-1:0] shift,
  output logic signed [ACC_W:0]   rnd,
  input  logic signed [ACC_W:0]   rnd_q,
  output q4_t                     q,
  output logic                    sat
);

  localparam int RW = ACC_W + 1;
  localparam logic signed [RW-1:0] R_MAX = RW'(Q_MAX);
  localparam logic signed [RW-1:0] R_MIN = RW'(Q_MIN);

  if (2**SHIFT_W > ACC_W) begin : g_bad_params
    $error("tanh_q_round_sat: 2**SHIFT_W must not exceed ACC_W");
  end

  logic signed [RW-1:0] ext;
  logic signed [RW-1:0] bias;
  logic signed [RW-1:0] sum;

  // One guard bit keeps acc + half-LSB bias from overflowing before the shift.
  always_comb begin
    ext  = {acc[ACC_W-1], acc};
    bias = '0;
    if (shift != '0) begin
      bias = {{ACC_W{1'b0}}, 1'b1} << (shift - 1'b1);
    end
    sum = ext + bias;
    rnd = sum >>> shift;
  end

  always_comb begin
    q   = rnd_q[Q_W-1:0];
    sat = 1'b0;
    if (rnd_q > R_MAX) begin
      q   = q4_t'(Q_MAX);
      sat = 1'b1;
    end else if (rnd_q < R_MIN) begin
      q   = q4_t'(Q_MIN);
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/tanh_in_requant_4bit.sv
// Two-stage valid/ready requantizer from ACC_W-bit accumulators to 4-bit tanh input codes,
// with a sticky saturation event counter for calibration.
module tanh_in_requant_4bit
  import tanh_q_pkg::*;
#(
  parameter int ACC_W    = 16,
  parameter int SHIFT_W  = 4,
  parameter int SATCNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [ACC_W-1:0]   in_data,
  input  logic        [SHIFT_W-1:0] in_shift,
  output logic                      out_valid,
  input  logic                      out_ready,
  output q4_t                       out_data,
  output logic                      out_sat,
  output logic        [SATCNT_W-1:0] sat_count,
  input  logic                      clr_sat
);

  logic                 s1_valid;
  logic signed [ACC_W:0] s1_r;
  logic signed [ACC_W:0] s1_next;
  q4_t                  s2_q;
  logic                 s2_sat;
  logic                 s1_load;
  logic                 s2_load;

  tanh_q_round_sat #(
    .ACC_W  (ACC_W),
    .SHIFT_W(SHIFT_W)
  ) u_round_sat (
    .acc  (in_data),
    .shift(in_shift),
    .rnd  (s1_next),
    .rnd_q(s1_r),
    .q    (s2_q),
    .sat  (s2_sat)
  );

  // in_ready is combinational through s2_load, so a full pipe still streams at one beat/cycle.
  always_comb begin
    s2_load  = s1_valid & (~out_valid | out_ready);
    in_ready = ~rst & (~s1_valid | s2_load);
    s1_load  = in_valid & in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_r      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      sat_count <= '0;
    end else begin
      s1_valid <= s1_load | (s1_valid & ~s2_load);
      if (s1_load) begin
        s1_r <= s1_next;
      end

      out_valid <= s2_load | (out_valid & ~out_ready);
      if (s2_load) begin
        out_data <= s2_q;
        out_sat  <= s2_sat;
      end

      if (clr_sat) begin
        sat_count <= '0;
      end else if (out_valid && out_ready && out_sat && (sat_count != '1)) begin
        sat_count <= sat_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tanh_in_requant_4bit.sv
// Scoreboard bench for tanh_in_requant_4bit: directed cases plus a randomized stall/valid soak.
module tb_tanh_in_requant_4bit;
  import tanh_q_pkg::*;

  localparam int ACC_W   = 16;
  localparam int SHIFT_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst       = 1'b1;
  logic               in_valid  = 1'b0;
  logic               out_ready = 1'b0;
  logic               clr_sat   = 1'b0;
  logic [ACC_W-1:0]   in_data   = '0;
  logic [SHIFT_W-1:0] in_shift  = '0;

  logic        in_ready, out_valid, out_sat;
  q4_t         out_data;
  logic [15:0] sat_count;
  logic        in_ready2, out_valid2, out_sat2;
  q4_t         out_data2;
  logic [1:0]  sat_count2;

  tanh_in_requant_4bit #(.ACC_W(ACC_W), .SHIFT_W(SHIFT_W), .SATCNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shift(in_shift), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .sat_count(sat_count), .clr_sat(clr_sat)
  );

  tanh_in_requant_4bit #(.ACC_W(ACC_W), .SHIFT_W(SHIFT_W), .SATCNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_shift(in_shift), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_sat(out_sat2),
    .sat_count(sat_count2), .clr_sat(clr_sat)
  );

  typedef struct packed { q4_t q; logic sat; } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, int got, int exp);
    n_checks++;
    if (got != exp) $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    else n_pass++;
  endtask

  // Reference: floor((x + half) / 2^s), then clamp to the q4 range.
  function automatic exp_t ref_model(int x, int s);
    exp_t e;
    int d, num, r;
    d   = 1 << s;
    num = x + ((s != 0) ? d / 2 : 0);
    r   = num / d;
    if ((num % d != 0) && (num < 0)) r--;
    e.sat = (r > Q_MAX) || (r < Q_MIN);
    if (r > Q_MAX) r = Q_MAX;
    if (r < Q_MIN) r = Q_MIN;
    e.q = q4_t'(r);
    return e;
  endfunction

  bit         drv_valid = 0, drv_ready = 0, drv_clr = 0, drv_rst = 1;
  logic [15:0] drv_data = '0;
  logic [3:0]  drv_shift = '0;
  bit         use_ovr = 0;
  exp_t       ovr;
  bit         accepted;

  task automatic step();
    @(negedge clk);
    rst       = drv_rst;
    in_valid  = drv_valid;
    in_data   = drv_valid ? drv_data : 'x;
    in_shift  = drv_valid ? drv_shift : 'x;
    out_ready = drv_ready;
    clr_sat   = drv_clr;
    #1;
    accepted = in_valid && in_ready;
    if (accepted) begin
      if (use_ovr) sb.push_back(ovr);
      else sb.push_back(ref_model(int'($signed(in_data)), int'(in_shift)));
    end
  endtask

  task automatic send(logic [15:0] d, logic [3:0] s, bit ovr_en, q4_t q, bit sat);
    drv_valid = 1; drv_data = d; drv_shift = s;
    use_ovr = ovr_en; ovr.q = q; ovr.sat = sat;
    for (int i = 0; i < 50; i++) begin
      step();
      if (accepted) break;
    end
    if (!accepted) check("send_timeout", 0, 1);
    drv_valid = 0; use_ovr = 0;
  endtask

  task automatic drain();
    drv_valid = 0; drv_ready = 1;
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    step();
    check("drain_empty", sb.size(), 0);
  endtask

  // Monitor: scoreboard pop, sat-count model, stall hold and reset behaviour.
  bit   post_rst = 0, prev_stall = 0;
  q4_t  prev_q;
  logic prev_sat;
  int   exp_sat = 0, exp_sat2 = 0;

  always @(negedge clk) begin
    exp_t e;
    bit   fire, got_e;
    #2;
    if (rst) begin
      check("in_ready_in_rst", in_ready, 0);
      sb.delete();
      exp_sat = 0; exp_sat2 = 0;
      post_rst = 1; prev_stall = 0;
    end else begin
      if (post_rst) begin
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_data", int'(out_data), 0);
        check("post_rst_out_sat", out_sat, 0);
        post_rst = 0;
      end
      check("sat_count", sat_count, exp_sat);
      check("sat_count_w2", sat_count2, exp_sat2);
      if (prev_stall) begin
        check("stall_valid_hold", out_valid, 1);
        check("stall_data_hold", int'(out_data), int'(prev_q));
        check("stall_sat_hold", out_sat, prev_sat);
      end
      fire  = out_valid && out_ready;
      got_e = 0;
      if (fire) begin
        if (sb.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          e = sb.pop_front();
          got_e = 1;
          check("out_data", int'(out_data), int'(e.q));
          check("out_sat", out_sat, e.sat);
        end
      end
      if (clr_sat) begin
        exp_sat = 0; exp_sat2 = 0;
      end else if (got_e && e.sat) begin
        if (exp_sat < 65535) exp_sat++;
        if (exp_sat2 < 3) exp_sat2++;
      end
      prev_stall = out_valid && !out_ready;
      prev_q = out_data; prev_sat = out_sat;
    end
  end

  initial begin
    int pi, n_soak, budget;
    logic [15:0] bp_data [4];

    drv_rst = 1;
    step(); step();
    drv_rst = 0;
    step();
    check("reset_sat_count", sat_count, 0);

    // Rounding with latency check
    drv_ready = 1;
    send(16'd19, 4'd2, 1, 4'h5, 0);
    step();
    check("lat_cycle1_out_valid", out_valid, 0);
    step();
    check("lat_cycle2_out_valid", out_valid, 1);
    send(16'hFFED, 4'd2, 1, 4'hB, 0);
    send(16'd2,    4'd2, 1, 4'h1, 0);
    send(16'hFFFE, 4'd2, 1, 4'h0, 0);

    // Saturation both ways
    send(16'h0100, 4'd2, 1, 4'h7, 1);
    send(16'h8000, 4'd0, 1, 4'h8, 1);
    drain();
    check("sat_count_after_two", sat_count, 2);

    // Backpressure: only two beats fit while stalled
    bp_data = '{16'd4, 16'd8, 16'd12, 16'd16};
    drv_ready = 0; pi = 0;
    for (int c = 0; c < 6; c++) begin
      drv_valid = (pi < 4);
      drv_data = bp_data[pi % 4]; drv_shift = 4'd2;
      use_ovr = 1; ovr.q = q4_t'(pi + 1); ovr.sat = 0;
      step();
      if (accepted) pi++;
    end
    check("bp_accepted", pi, 2);
    check("bp_in_ready_low", in_ready, 0);
    drv_ready = 1;
    for (int c = 0; c < 40 && pi < 4; c++) begin
      drv_valid = 1;
      drv_data = bp_data[pi]; drv_shift = 4'd2;
      use_ovr = 1; ovr.q = q4_t'(pi + 1); ovr.sat = 0;
      step();
      if (accepted) pi++;
    end
    check("bp_all_offered", pi, 4);
    drain();

    // Counter saturation and clear priority
    drv_clr = 1; step(); drv_clr = 0;
    for (int i = 0; i < 5; i++) send(16'h7FFF, 4'd0, 1, 4'h7, 1);
    drain();
    check("satcnt_w2_sticks", sat_count2, 3);
    check("satcnt_w16_counts", sat_count, 5);
    drv_ready = 0;
    send(16'h8000, 4'd0, 1, 4'h8, 1);
    for (int i = 0; i < 10 && !out_valid; i++) step();
    drv_ready = 1; drv_clr = 1;
    step();
    check("clr_coincide_delivery", out_valid && out_sat, 1);
    drv_clr = 0;
    step();
    check("clr_wins_w16", sat_count, 0);
    check("clr_wins_w2", sat_count2, 0);

    // Reset with both stages full
    send(16'h7FFF, 4'd0, 1, 4'h7, 1);
    drain();
    check("pre_rst_sat_count", sat_count, 1);
    drv_ready = 0;
    send(16'd12, 4'd2, 1, 4'h3, 0);
    send(16'd20, 4'd2, 1, 4'h5, 0);
    step();
    check("pre_rst_full", in_ready, 0);
    drv_rst = 1; step(); drv_rst = 0;
    step();
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_sat_count", sat_count, 0);
    check("rst_mid_in_ready", in_ready, 1);

    // Random soak
    n_soak = 0; budget = 0;
    while (n_soak < 10000 && budget < 60000) begin
      drv_valid = ($urandom_range(0, 9) < 7);
      drv_data  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 127) - 64);
      drv_shift = 4'($urandom_range(0, 15));
      drv_ready = ($urandom_range(0, 3) != 0);
      drv_clr   = ($urandom_range(0, 499) == 0);
      drv_rst   = ($urandom_range(0, 2999) == 0);
      use_ovr   = 0;
      step();
      if (accepted) n_soak++;
      budget++;
    end
    check("soak_beats", n_soak, 10000);
    drv_rst = 0; drv_clr = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
